// File: rtl/id4s_pkg.sv
// Shared constants and types for the ID4s four-lane pulse array.
// Optional XNOR output mode is selected with ID4S_INVERT_R_EN.
package id4s_pkg;

    localparam int LANES = 4;
    localparam int R_EXTRA_LAT_MAX = 3;

    typedef logic [LANES-1:0] lane_vec_t;

endpackage

// File: rtl/id4s_lane.sv
// One ID4s lane: Q register, data/control delay lines and R register.
// ID4S_INVERT_R_EN selects XNOR for R and holds R at 0 until the pipe fills.
module id4s_lane
    import id4s_pkg::*;
#(
    parameter int R_EXTRA_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    input  logic x,
    output logic q,
    output logic r
);

    if (R_EXTRA_LAT < 1 || R_EXTRA_LAT > R_EXTRA_LAT_MAX) begin : g_bad_lat
        $error("id4s_lane: R_EXTRA_LAT out of range");
    end

    // d_line[0] is the Q register; deeper taps carry data until R is due
    logic [R_EXTRA_LAT-1:0] d_line;
    logic [R_EXTRA_LAT-1:0] x_line;
    logic                   r_mix;

    assign q     = d_line[0];
    assign r_mix = d_line[R_EXTRA_LAT-1] ^ x_line[R_EXTRA_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_line <= '0;
            x_line <= '0;
        end else begin
            d_line[0] <= d;
            x_line[0] <= x;
            for (int i = 1; i < R_EXTRA_LAT; i++) begin
                d_line[i] <= d_line[i-1];
                x_line[i] <= x_line[i-1];
            end
        end
    end

`ifdef ID4S_INVERT_R_EN
    localparam logic [1:0] FILL_MAX = 2'(R_EXTRA_LAT);

    // Counts edges since reset release; R is meaningful once the taps hold real samples
    logic [1:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
            r    <= 1'b0;
        end else begin
            if (fill < FILL_MAX) begin
                fill <= fill + 2'd1;
            end
            r <= (fill >= FILL_MAX) ? ~r_mix : 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= 1'b0;
        end else begin
            r <= r_mix;
        end
    end
`endif

endmodule

// File: rtl/id4s_core.sv
// ID4s macro top: packs pad bits into lane vectors and instantiates the lanes.
// Optional XNOR output mode is selected with ID4S_INVERT_R_EN.
module id4s_core
    import id4s_pkg::*;
#(
    parameter int R_EXTRA_LAT = 1
) (
    input  logic GCLK_Pad,
    input  logic RSTN_Pad,
    input  logic D0_Pad,
    input  logic D1_Pad,
    input  logic D2_Pad,
    input  logic D3_Pad,
    input  logic X0_Pad,
    input  logic X1_Pad,
    input  logic X2_Pad,
    input  logic X3_Pad,
    output logic Q0_Pad,
    output logic Q1_Pad,
    output logic Q2_Pad,
    output logic Q3_Pad,
    output logic R0_Pad,
    output logic R1_Pad,
    output logic R2_Pad,
    output logic R3_Pad
);

    lane_vec_t d_vec;
    lane_vec_t x_vec;
    lane_vec_t q_vec;
    lane_vec_t r_vec;

    assign d_vec = {D3_Pad, D2_Pad, D1_Pad, D0_Pad};
    assign x_vec = {X3_Pad, X2_Pad, X1_Pad, X0_Pad};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        id4s_lane #(
            .R_EXTRA_LAT(R_EXTRA_LAT)
        ) u_lane (
            .clk  (GCLK_Pad),
            .rst_n(RSTN_Pad),
            .d    (d_vec[i]),
            .x    (x_vec[i]),
            .q    (q_vec[i]),
            .r    (r_vec[i])
        );
    end

    assign {Q3_Pad, Q2_Pad, Q1_Pad, Q0_Pad} = q_vec;
    assign {R3_Pad, R2_Pad, R1_Pad, R0_Pad} = r_vec;

endmodule

// File: tb/tb_id4s_core.sv
// Self-checking bench for id4s_core with R_EXTRA_LAT=1.
// Table-driven vectors plus reset and random sequences through a scoreboard queue.
module tb_id4s_core;
    import id4s_pkg::*;

    logic clk;
    logic rst_n;
    lane_vec_t d;
    lane_vec_t x;
    lane_vec_t q;
    lane_vec_t r;

    int checks = 0;
    int failures = 0;

`ifdef ID4S_INVERT_R_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    typedef struct {
        lane_vec_t d;
        lane_vec_t x;
        lane_vec_t q_exp;
        lane_vec_t r_exp;
    } vec_t;

    typedef struct {
        lane_vec_t q;
        lane_vec_t r;
        string     name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];

    id4s_core #(
        .R_EXTRA_LAT(1)
    ) dut (
        .GCLK_Pad(clk),
        .RSTN_Pad(rst_n),
        .D0_Pad(d[0]), .D1_Pad(d[1]), .D2_Pad(d[2]), .D3_Pad(d[3]),
        .X0_Pad(x[0]), .X1_Pad(x[1]), .X2_Pad(x[2]), .X3_Pad(x[3]),
        .Q0_Pad(q[0]), .Q1_Pad(q[1]), .Q2_Pad(q[2]), .Q3_Pad(q[3]),
        .R0_Pad(r[0]), .R1_Pad(r[1]), .R2_Pad(r[2]), .R3_Pad(r[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic lane_vec_t rmap(input lane_vec_t xr);
        return INV ? ~xr : xr;
    endfunction

    task automatic check(input string name, input lane_vec_t eq,
                         input lane_vec_t er);
        checks++;
        if (q !== eq || r !== er) begin
            failures++;
            $display("FAIL %s: got Q=%b R=%b, expected Q=%b R=%b",
                     name, q, r, eq, er);
        end
    endtask

    // Drive one sample, push its expectation, clock it, then pop and compare
    task automatic step(input string name, input lane_vec_t dv,
                        input lane_vec_t xv, input lane_vec_t eq,
                        input lane_vec_t er);
        exp_t e;
        @(negedge clk);
        d = dv;
        x = xv;
        e.q = eq;
        e.r = er;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got Q=%b R=%b", name, q, r);
        end else begin
            e = sb.pop_front();
            check(e.name, e.q, e.r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = '0;
            x = '0;
        end
    endtask

    initial begin
        lane_vec_t dp;
        lane_vec_t xp;
        lane_vec_t dn;
        lane_vec_t xn;

        tbl[0] = '{4'b1100, 4'b1011, 4'b1100, 4'b0000};
        tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0111};
        tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3] = '{4'b1100, 4'b1111, 4'b1100, 4'b0000};
        tbl[4] = '{4'b0011, 4'b1001, 4'b0011, 4'b0011};
        tbl[5] = '{4'b1110, 4'b0000, 4'b1110, 4'b1010};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1110};
        tbl[7] = '{4'b0000, 4'b0101, 4'b0000, 4'b0000};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0101};

        d = '0;
        x = '0;
        rst_n = 1'b0;
        #1;
        check("reset_async", 4'b0000, 4'b0000);

        // Random inputs while held in reset must not leak through
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d = lane_vec_t'($urandom_range(0, 15));
            x = lane_vec_t'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), 4'b0000, 4'b0000);
        end

        @(negedge clk);
        d = '0;
        x = '0;
        rst_n = 1'b1;
        idle(3);
        #1;
        check("idle_filled", 4'b0000, rmap(4'b0000));

        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), tbl[i].d, tbl[i].x,
                 tbl[i].q_exp, rmap(tbl[i].r_exp));
        end

        // Reset between the Q and R cycles of a single sample
        step("rst_mid_q", 4'b1100, 4'b1011, 4'b1100, rmap(4'b0000));
        d = '0;
        x = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_mid_hold%0d", i), 4'b0000, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        d = 4'b0110;
        x = 4'b0000;
        @(posedge clk);
        #1;
        check("post_rst_q", 4'b0110, 4'b0000);
        step("post_rst_r", 4'b0000, 4'b0000, 4'b0000,
             INV ? 4'b1001 : 4'b0110);
        step("post_rst_idle", 4'b0000, 4'b0000, 4'b0000, rmap(4'b0000));

        // Random back-to-back traffic against a one-sample history model
        dp = '0;
        xp = '0;
        for (int i = 0; i < 40; i++) begin
            dn = lane_vec_t'($urandom_range(0, 15));
            xn = lane_vec_t'($urandom_range(0, 15));
            step($sformatf("rand%0d", i), dn, xn, dn, rmap(dp ^ xp));
            dp = dn;
            xp = xn;
        end
        step("rand_drain", 4'b0000, 4'b0000, 4'b0000, rmap(dp ^ xp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
